// File: rtl/mixer_nch_pkg.sv
// Shared types and limits for the N-channel stereo mixer.
package mixer_nch_pkg;

    // Per-channel stereo routing: bit 0 feeds left, bit 1 feeds right.
    typedef enum logic [1:0] {
        PAN_OFF = 2'b00,
        PAN_L   = 2'b01,
        PAN_R   = 2'b10,
        PAN_LR  = 2'b11
    } pan_t;

    localparam int unsigned MIXER_MAX_CH = 16;

    function automatic logic pan_to_left(input pan_t pan);
        return pan[0];
    endfunction

    function automatic logic pan_to_right(input pan_t pan);
        return pan[1];
    endfunction

endpackage

// File: rtl/mixer_nch_sigma_delta_dac.sv
// First-order sigma-delta 1-bit DAC: the output is the registered carry of a
// phase accumulator, so ones density equals din / 2^W.
module sigma_delta_dac
    import mixer_nch_pkg::*;
#(
    parameter int unsigned W = 11
) (
    input  logic         clk28,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic         dout
);

    logic [W:0] mod_q;
    logic [W:0] mod_d;

    // Drop the previous carry and add the new input; the new carry is the output bit.
    always_comb begin
        mod_d = {1'b0, mod_q[W-1:0]} + {1'b0, din};
    end

    // Modulator state register.
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            mod_q <= '0;
        end else begin
            mod_q <= mod_d;
        end
    end

    assign dout = mod_q[W];

endmodule

// File: rtl/mixer_nch.sv
// N-channel stereo mixer: one time-shared adder walks the channels slot by
// slot, latches stereo sums once per pass, and feeds two sigma-delta DACs.
// Optional per-channel attenuation shifter enabled by defining MIXER_ATTEN_EN.
module mixer_nch
    import mixer_nch_pkg::*;
#(
    parameter int unsigned CHANNELS = 6,
    parameter int unsigned WIDTH    = 8
) (
    input  logic                                 clk28,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic [CHANNELS*WIDTH-1:0]            ch_data,
    input  logic [CHANNELS*2-1:0]                ch_pan,
    input  logic [CHANNELS*2-1:0]                ch_atten,
    output logic [WIDTH+$clog2(CHANNELS)-1:0]    sum_l,
    output logic [WIDTH+$clog2(CHANNELS)-1:0]    sum_r,
    output logic                                 mix_valid,
    output logic                                 dac_l,
    output logic                                 dac_r
);

    localparam int unsigned SLOT_W = $clog2(CHANNELS);
    localparam int unsigned SUM_W  = WIDTH + $clog2(CHANNELS);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHANNELS - 1);

    logic [SLOT_W-1:0] slot_q,  slot_d;
    logic [SUM_W-1:0]  acc_l_q, acc_l_d;
    logic [SUM_W-1:0]  acc_r_q, acc_r_d;
    logic [SUM_W-1:0]  sum_l_q, sum_l_d;
    logic [SUM_W-1:0]  sum_r_q, sum_r_d;
    logic              mix_valid_q, mix_valid_d;

    logic [WIDTH-1:0]  raw_sample;
    logic [WIDTH-1:0]  sample;
    pan_t              pan;
    logic [SUM_W-1:0]  contrib_l;
    logic [SUM_W-1:0]  contrib_r;

    // Pick the current slot's sample and pan; route the contribution per side.
    always_comb begin
        raw_sample = ch_data[slot_q*WIDTH +: WIDTH];
        pan        = pan_t'(ch_pan[slot_q*2 +: 2]);
        contrib_l  = pan_to_left(pan)  ? SUM_W'(sample) : '0;
        contrib_r  = pan_to_right(pan) ? SUM_W'(sample) : '0;
    end

`ifdef MIXER_ATTEN_EN
    assign sample = raw_sample >> ch_atten[slot_q*2 +: 2];
`else
    // Attenuation port kept for wiring compatibility but has no effect.
    logic unused_atten;
    assign unused_atten = ^ch_atten;
    assign sample       = raw_sample;
`endif

    // Slot sequencing: load at slot 0, accumulate in the middle, latch at the last slot.
    always_comb begin
        slot_d      = slot_q;
        acc_l_d     = acc_l_q;
        acc_r_d     = acc_r_q;
        sum_l_d     = sum_l_q;
        sum_r_d     = sum_r_q;
        mix_valid_d = 1'b0;
        if (en) begin
            slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);
            if (slot_q == '0) begin
                acc_l_d = contrib_l;
                acc_r_d = contrib_r;
            end else if (slot_q != LAST_SLOT) begin
                acc_l_d = acc_l_q + contrib_l;
                acc_r_d = acc_r_q + contrib_r;
            end else begin
                sum_l_d     = acc_l_q + contrib_l;
                sum_r_d     = acc_r_q + contrib_r;
                mix_valid_d = 1'b1;
            end
        end
    end

    // Mixer state registers; reset discards any partial pass.
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            slot_q      <= '0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            sum_l_q     <= '0;
            sum_r_q     <= '0;
            mix_valid_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            acc_l_q     <= acc_l_d;
            acc_r_q     <= acc_r_d;
            sum_l_q     <= sum_l_d;
            sum_r_q     <= sum_r_d;
            mix_valid_q <= mix_valid_d;
        end
    end

    assign sum_l     = sum_l_q;
    assign sum_r     = sum_r_q;
    assign mix_valid = mix_valid_q;

    sigma_delta_dac #(.W(SUM_W)) u_dac_l (
        .clk28 (clk28),
        .rst   (rst),
        .din   (sum_l_q),
        .dout  (dac_l)
    );

    sigma_delta_dac #(.W(SUM_W)) u_dac_r (
        .clk28 (clk28),
        .rst   (rst),
        .din   (sum_r_q),
        .dout  (dac_r)
    );

endmodule

// File: tb/tb_mixer_nch.sv
// Directed self-checking bench for mixer_nch (CHANNELS=6, WIDTH=8, SUM_W=11).
module tb_mixer_nch;
    import mixer_nch_pkg::*;

    localparam int unsigned CHANNELS = 6;
    localparam int unsigned WIDTH    = 8;
    localparam int unsigned SUM_W    = 11;

    logic                      clk28 = 1'b0;
    logic                      rst;
    logic                      en;
    logic [CHANNELS*WIDTH-1:0] ch_data;
    logic [CHANNELS*2-1:0]     ch_pan;
    logic [CHANNELS*2-1:0]     ch_atten;
    logic [SUM_W-1:0]          sum_l;
    logic [SUM_W-1:0]          sum_r;
    logic                      mix_valid;
    logic                      dac_l;
    logic                      dac_r;

    int errors = 0;
    int checks = 0;

    mixer_nch #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) dut (
        .clk28     (clk28),
        .rst       (rst),
        .en        (en),
        .ch_data   (ch_data),
        .ch_pan    (ch_pan),
        .ch_atten  (ch_atten),
        .sum_l     (sum_l),
        .sum_r     (sum_r),
        .mix_valid (mix_valid),
        .dac_l     (dac_l),
        .dac_r     (dac_r)
    );

    always #5 clk28 = ~clk28;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_all();
        ch_data  = '0;
        ch_pan   = '0;
        ch_atten = '0;
    endtask

    task automatic set_ch(input int k, input logic [7:0] val, input pan_t pan, input logic [1:0] att);
        ch_data[k*WIDTH +: WIDTH] = val;
        ch_pan[k*2 +: 2]          = pan;
        ch_atten[k*2 +: 2]        = att;
    endtask

    // Returns the number of falling edges until mix_valid is seen (bounded).
    task automatic wait_valid(input string tag, output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 40) begin
            @(negedge clk28);
            n++;
            seen = mix_valid;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    // Discard any pass mixed across an input change, stop on a clean one.
    task automatic settle(input string tag);
        int n;
        wait_valid({tag, "_a"}, n);
        wait_valid({tag, "_b"}, n);
    endtask

    initial begin
        int n;
        int ones_l, ones_r, vcnt, held_bad;

        rst = 1'b1;
        en  = 1'b0;
        clear_all();
        repeat (3) @(negedge clk28);
        check("rst_sum_l", 32'(sum_l), 0);
        check("rst_sum_r", 32'(sum_r), 0);
        check("rst_valid", 32'(mix_valid), 0);
        check("rst_dac_l", 32'(dac_l), 0);
        check("rst_dac_r", 32'(dac_r), 0);

        // Single full-scale channel to both sides; first pass timing and period.
        set_ch(0, 8'd255, PAN_LR, 2'd0);
        en  = 1'b1;
        rst = 1'b0;
        wait_valid("t1_first", n);
        check("t1_first_latency", 32'(n), 6);
        check("t1_sum_l", 32'(sum_l), 255);
        check("t1_sum_r", 32'(sum_r), 255);
        wait_valid("t1_period", n);
        check("t1_period_len", 32'(n), 6);
        @(negedge clk28);
        check("t1_valid_one_cycle", 32'(mix_valid), 0);

        // Mixed pans: left = 100 + 7, right = 50 + 7.
        clear_all();
        set_ch(0, 8'd100, PAN_L,   2'd0);
        set_ch(1, 8'd50,  PAN_R,   2'd0);
        set_ch(2, 8'd20,  PAN_OFF, 2'd0);
        set_ch(3, 8'd7,   PAN_LR,  2'd0);
        settle("t2");
        check("t2_sum_l", 32'(sum_l), 107);
        check("t2_sum_r", 32'(sum_r), 57);

        // Worst case 6*255 = 1530 fits in 11 bits; exactly 1530 ones per 2048 cycles.
        for (int k = 0; k < 6; k++) set_ch(k, 8'd255, PAN_LR, 2'd0);
        settle("t3");
        check("t3_sum_l", 32'(sum_l), 1530);
        check("t3_sum_r", 32'(sum_r), 1530);
        ones_l = 0;
        ones_r = 0;
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk28);
            ones_l += int'(dac_l);
            ones_r += int'(dac_r);
        end
        check("t3_dac_l_ones", 32'(ones_l), 1530);
        check("t3_dac_r_ones", 32'(ones_r), 1530);

        // Zero mix gives a silent DAC.
        clear_all();
        settle("t3z");
        check("t3z_sum_l", 32'(sum_l), 0);
        repeat (2) @(negedge clk28);
        ones_l = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk28);
            ones_l += int'(dac_l);
        end
        check("t3z_dac_l_ones", 32'(ones_l), 0);

        // Freeze at slot 3: L = 200+255+90+33 = 578, R = 150+255+60+33 = 498.
        set_ch(0, 8'd200, PAN_L,  2'd0);
        set_ch(1, 8'd150, PAN_R,  2'd0);
        set_ch(2, 8'd255, PAN_LR, 2'd0);
        set_ch(3, 8'd90,  PAN_L,  2'd0);
        set_ch(4, 8'd60,  PAN_R,  2'd0);
        set_ch(5, 8'd33,  PAN_LR, 2'd0);
        settle("t4");
        check("t4_sum_l", 32'(sum_l), 578);
        check("t4_sum_r", 32'(sum_r), 498);
        repeat (3) @(negedge clk28);
        en = 1'b0;
        vcnt = 0; held_bad = 0; ones_l = 0; ones_r = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk28);
            vcnt     += int'(mix_valid);
            held_bad += int'(sum_l != 11'd578 || sum_r != 11'd498);
            ones_l   += int'(dac_l);
            ones_r   += int'(dac_r);
        end
        check("t4_freeze_no_valid", 32'(vcnt), 0);
        check("t4_freeze_sums_held", 32'(held_bad), 0);
        check("t4_freeze_dac_l_active", 32'(ones_l != 0), 1);
        check("t4_freeze_dac_r_active", 32'(ones_r != 0), 1);
        en = 1'b1;
        wait_valid("t4_resume", n);
        check("t4_resume_from_slot3", 32'(n), 3);
        check("t4_resume_sum_l", 32'(sum_l), 578);
        check("t4_resume_sum_r", 32'(sum_r), 498);

        // Asynchronous reset mid-pass at slot 4.
        repeat (4) @(negedge clk28);
        #1 rst = 1'b1;
        #1;
        check("t5_async_sum_l", 32'(sum_l), 0);
        check("t5_async_sum_r", 32'(sum_r), 0);
        check("t5_async_valid", 32'(mix_valid), 0);
        check("t5_async_dac_l", 32'(dac_l), 0);
        check("t5_async_dac_r", 32'(dac_r), 0);
        repeat (2) @(negedge clk28);
        rst = 1'b0;
        wait_valid("t5_after", n);
        check("t5_first_valid_latency", 32'(n), 6);
        check("t5_sum_l", 32'(sum_l), 578);
        check("t5_sum_r", 32'(sum_r), 498);

        // Attenuation: 200 >> 2 = 50 when the shifter is built, else untouched.
        clear_all();
        set_ch(0, 8'd200, PAN_L, 2'd2);
        settle("t6");
`ifdef MIXER_ATTEN_EN
        check("t6_atten_sum_l", 32'(sum_l), 50);
`else
        check("t6_atten_sum_l", 32'(sum_l), 200);
`endif
        check("t6_atten_sum_r", 32'(sum_r), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
